dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage data port (ALU_Out/WE_DM/WD_DM -> RD_DM).
//  Posts stores into a small write buffer and forwards buffered data to loads. Drains stores
//  and serves load misses over a req/ack bus to variable-latency external memory.
//  Mem_Stall freezes the pipeline through the Hazard_Unit while a load miss or buffer-full store is pending.
// PARAMETERS
//  WB_DEPTH  4   write-buffer entries (power of 2, >=2)
//  ADDR_W    32  byte address width; bits [1:0] ignored (word access only)
//  DATA_W    32  data word width
// PORTS
//  CLK        in   1       clock; all state updates on rising edge
//  RST        in   1       asynchronous, active-low reset
//  ALU_Out    in   ADDR_W  MEM-stage address
//  WE_DM      in   1       store request
//  WD_DM      in   DATA_W  store data
//  RE_DM      in   1       load request (RF_WD_Src_MEM selects DM)
//  RD_DM      out  DATA_W  load data, valid in cycle Mem_Stall=0 with RE_DM=1
//  Mem_Stall  out  1       hold PC/IF/ID/EXE/MEM; request inputs are held stable while high
//  Bus_Req    out  1       external request valid
//  Bus_WE     out  1       1=write, 0=read
//  Bus_Addr   out  ADDR_W  word-aligned address ([1:0]=0)
//  Bus_WD     out  DATA_W  write data
//  Bus_Ack    in   1       one-cycle completion pulse
//  Bus_RD     in   DATA_W  read data, valid with Bus_Ack
// BEHAVIOUR
//  Reset: FSM=IDLE, buffer empty. Bus_Req=0, Bus_WE=0, Bus_Addr=0, Bus_WD=0, Mem_Stall=0, RD_DM=0.
//   Reset mid-transaction aborts the bus request immediately. Buffered stores are discarded.
//  FSM states: IDLE, WR_BUSY, RD_BUSY, RD_DONE. Bus_Req=1 exactly in WR_BUSY/RD_BUSY.
//   Bus_Addr/WE/WD are registered on entry and stable until Bus_Ack.
//  Store: WE_DM & count<WB_DEPTH -> enqueue {addr[ADDR_W-1:2],data} at edge, Mem_Stall=0.
//   If full (registered count==WB_DEPTH), Mem_Stall=1 and no enqueue.
//   The store is retried each cycle and accepted the cycle after a pop.
//  Load hit: RE_DM & word address matches any entry -> RD_DM = youngest matching entry
//   (combinational), Mem_Stall=0, 0-cycle latency.
//  Load miss: Mem_Stall=1 combinationally.
//   IDLE -> RD_BUSY. On Bus_Ack, latch Bus_RD into rd_hold and go to RD_DONE.
//   RD_DONE: Mem_Stall=0, RD_DM=rd_hold for one cycle, then IDLE.
//   A miss in WR_BUSY waits for that write's Bus_Ack, then enters RD_BUSY. Stall stays high throughout.
//  Drain: IDLE & buffer non-empty & no load miss -> WR_BUSY with the head entry.
//   On Bus_Ack, pop the head and return to IDLE. Load miss has priority over drain in IDLE.
//   Stores drain in strict FIFO order. Same-address stores are not coalesced.
//  Simultaneous enqueue+pop: both occur; count unchanged. Pointers wrap modulo WB_DEPTH.
//  RD_DM=0 when no hit and not RD_DONE.
//  WE_DM&RE_DM together is illegal: store wins. The bench flags it with an assertion.
//  Bus_Ack outside WR_BUSY/RD_BUSY is ignored.
// STRUCTURE
//  dmem_pkg: state encoding localparams (IDLE/WR_BUSY/RD_BUSY/RD_DONE), entry field widths, WB_DEPTH default.
//  Sub-module write_buffer: circular FIFO (head/tail/count) plus parallel address-match lookup
//   returning youngest hit data. Top level holds the FSM, bus registers, rd_hold and stall logic.
// TESTING
//  1 Store 0x100<-0xDEADBEEF, Bus_Ack held 0; load 0x100 next cycle
//    -> RD_DM=0xDEADBEEF, Mem_Stall=0, no bus read issued.
//  2 Five back-to-back stores, Bus_Ack held 0 -> 5th store sees Mem_Stall=1.
//    Ack first write -> 5th store enqueued next cycle, count=4.
//  3 Load miss 0x200, Bus_Ack 3 cycles after Bus_Req with Bus_RD=0x12345678
//    -> Mem_Stall high until Ack cycle inclusive; next cycle RD_DM=0x12345678, Mem_Stall=0.
//  4 Store 0x40<-1, store 0x40<-2, load 0x40 -> RD_DM=2.
//    Bus then shows writes (0x40,1) then (0x40,2) in order.
//  5 RST low during RD_BUSY -> Bus_Req=0, Mem_Stall=0, count=0 asynchronously; FSM=IDLE after release.
//  6 Load miss 0x300 while WR_BUSY draining 0x40 -> write acked first, then Bus_Req read 0x300.
//    Stall is continuous until read Ack.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and default geometry for the data-memory responder
package dmem_pkg;
  localparam int WB_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int BYTE_OFS_W   = 2;
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_DONE} state_t;
endpackage

// File: rtl/write_buffer.sv
// write_buffer: circular posted-store FIFO with a parallel youngest-match lookup for loads
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  input  logic [AW-1:0] i_look_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_hit,
  output logic [DW-1:0] o_hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(i_push);
      r_head  <= r_head + PW'(i_pop);
      r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  // entry storage needs no reset: occupancy gates every read
  always_ff @(posedge i_clk)
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  assign o_full      = r_count == (PW+1)'(DEPTH);
  assign o_empty     = r_count == '0;
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  // scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (k < int'(r_count) && r_addr[r_head + PW'(k)] == i_look_addr) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[r_head + PW'(k)];
      end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data port with posted write buffer and req/ack external memory bus
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_alu_out,
  input  logic              i_we_dm,
  input  logic [DATA_W-1:0] i_wd_dm,
  input  logic              i_re_dm,
  output logic [DATA_W-1:0] o_rd_dm,
  output logic              o_mem_stall,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wd,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rd
);
  localparam int AW = ADDR_W - BYTE_OFS_W;
  state_t            r_state, w_nxt;
  logic [DATA_W-1:0] r_rd_hold;
  logic              w_full, w_empty, w_hit, w_miss, w_push, w_pop, w_ld_rd, w_ld_wr;
  logic [AW-1:0]     w_head_addr;
  logic [DATA_W-1:0] w_head_data, w_hit_data;
  logic              w_unused;
  assign w_unused = ^i_alu_out[BYTE_OFS_W-1:0];
  write_buffer #(.DEPTH(WB_DEPTH), .AW(AW), .DW(DATA_W)) u_wb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_addr (i_alu_out[ADDR_W-1:BYTE_OFS_W]),
    .i_push_data (i_wd_dm),
    .i_pop       (w_pop),
    .i_look_addr (i_alu_out[ADDR_W-1:BYTE_OFS_W]),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_hit       (w_hit),
    .o_hit_data  (w_hit_data)
  );
  assign w_push      = i_we_dm & ~w_full;
  assign w_miss      = i_re_dm & ~i_we_dm & ~w_hit & (r_state != RD_DONE);
  assign o_mem_stall = i_rst_n & (w_miss | (i_we_dm & w_full));
  assign o_bus_req   = (r_state == WR_BUSY) || (r_state == RD_BUSY);
  assign o_rd_dm     = (r_state == RD_DONE) ? r_rd_hold : (i_re_dm & w_hit) ? w_hit_data : '0;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  // next state: a load miss outranks draining, and a miss behind a write chains straight into the read
  always_comb begin
    w_nxt   = r_state;
    w_ld_rd = 1'b0;
    w_ld_wr = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ld_rd = w_miss;
        w_ld_wr = ~w_miss & ~w_empty;
        w_nxt   = w_miss ? RD_BUSY : ~w_empty ? WR_BUSY : IDLE;
      end
      WR_BUSY: begin
        w_pop   = i_bus_ack;
        w_ld_rd = i_bus_ack & w_miss;
        w_nxt   = ~i_bus_ack ? WR_BUSY : w_miss ? RD_BUSY : IDLE;
      end
      RD_BUSY: w_nxt = i_bus_ack ? RD_DONE : RD_BUSY;
      default: w_nxt = IDLE;
    endcase
  end
  // bus fields are captured on entry to a busy state and held until acknowledged
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_wd   <= '0;
      r_rd_hold  <= '0;
    end else begin
      if (w_ld_rd) begin
        o_bus_we   <= 1'b0;
        o_bus_addr <= {i_alu_out[ADDR_W-1:BYTE_OFS_W], {BYTE_OFS_W{1'b0}}};
        o_bus_wd   <= '0;
      end else if (w_ld_wr) begin
        o_bus_we   <= 1'b1;
        o_bus_addr <= {w_head_addr, {BYTE_OFS_W{1'b0}}};
        o_bus_wd   <= w_head_data;
      end
      if (r_state == RD_BUSY && i_bus_ack) r_rd_hold <= i_bus_rd;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench against a program-order memory model
module tb_dmem_responder;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  logic        clk, rst_n, we_dm, re_dm, bus_ack;
  logic [31:0] alu, wd, bus_rd;
  logic [31:0] rd_dm, bus_addr, bus_wd;
  logic        mem_stall, bus_req, bus_we;
  int          n_chk = 0, n_err = 0;
  bit          auto_ack = 0, ack_req = 0;
  int          wait_cnt = 0;
  logic [31:0] ext_mem [256];
  logic [31:0] ref_arch [256];
  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_ld [$];

  dmem_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_alu_out(alu), .i_we_dm(we_dm), .i_wd_dm(wd),
    .i_re_dm(re_dm), .o_rd_dm(rd_dm), .o_mem_stall(mem_stall), .o_bus_req(bus_req),
    .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wd(bus_wd), .i_bus_ack(bus_ack),
    .i_bus_rd(bus_rd)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  always @(posedge clk)
    if (rst_n) assert (!(we_dm && re_dm)) else $error("illegal simultaneous WE_DM and RE_DM");

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // issue an access and record what the architecture says must result
  task automatic set_in(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    bit hit;
    hit = 0;
    we_dm = we; re_dm = re; alu = a; wd = d;
    if (we) begin
      ref_arch[a[9:2]] = d;
      exp_wr.push_back(wr_t'{a: a & ~32'h3, d: d});
    end else if (re) begin
      foreach (exp_wr[i]) if (exp_wr[i].a[9:2] == a[9:2]) hit = 1;
      if (!hit) exp_rd.push_back(a & ~32'h3);
      exp_ld.push_back(ref_arch[a[9:2]]);
    end
  endtask

  task automatic idle_in();
    we_dm = 0; re_dm = 0; alu = 0; wd = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    set_in(we, re, a, d);
    @(negedge clk);
    while (mem_stall && n < 60) begin n++; @(negedge clk); end
    chk("op_stall_bound", {31'b0, mem_stall}, 0);
    tick();
    idle_in();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || bus_req) && n < 300) begin n++; tick(); end
    chk("drain_bound", exp_wr.size(), 0);
  endtask

  // bus slave: one-cycle ack pulses, either on request or automatically with random latency
  initial begin
    bus_ack = 0; bus_rd = 0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 0;
      if (!rst_n) begin
        ack_req = 0; wait_cnt = 0;
      end else if (ack_req) begin
        ack_req = 0; bus_ack = 1;
      end else if (auto_ack && bus_req) begin
        if (wait_cnt == 0) begin bus_ack = 1; wait_cnt = $urandom_range(0, 3); end
        else wait_cnt--;
      end
      if (bus_ack && !bus_we) bus_rd = ext_mem[bus_addr[9:2]];
    end
  end

  // monitor: pops expectations whenever the DUT completes a bus transfer or a load
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_req && bus_ack) begin
          if (bus_we) begin
            if (exp_wr.size() == 0) begin
              n_chk++; n_err++;
              $display("FAIL bus_wr_extra: got write %h expected none", bus_addr);
            end else begin
              e = exp_wr.pop_front();
              chk("bus_wr_addr", bus_addr, e.a);
              chk("bus_wr_data", bus_wd, e.d);
            end
            ext_mem[bus_addr[9:2]] = bus_wd;
          end else if (exp_rd.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL bus_rd_extra: got read %h expected none", bus_addr);
          end else chk("bus_rd_addr", bus_addr, exp_rd.pop_front());
        end
        if (re_dm && !we_dm && !mem_stall) begin
          if (exp_ld.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL load_extra: got %h expected none", rd_dm);
          end else chk("rd_dm", rd_dm, exp_ld.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ext_mem[i] = 32'hC0DE_0000 | i;
    ext_mem[8'h80] = 32'h1234_5678;
    ref_arch = ext_mem;
    idle_in();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_bus_req", {31'b0, bus_req}, 0);
    chk("rst_bus_we", {31'b0, bus_we}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wd", bus_wd, 0);
    chk("rst_stall", {31'b0, mem_stall}, 0);
    chk("rst_rd_dm", rd_dm, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick();

    // store then immediate load of the same word is forwarded from the buffer
    op(1, 0, 32'h100, 32'hDEAD_BEEF);
    set_in(0, 1, 32'h100, 0);
    @(negedge clk);
    chk("t1_rd_dm", rd_dm, 32'hDEAD_BEEF);
    chk("t1_stall", {31'b0, mem_stall}, 0);
    chk("t1_no_bus_read", {31'b0, bus_req & ~bus_we}, 0);
    tick(); idle_in();
    auto_ack = 1; wait_drain(); tick(); auto_ack = 0;

    // fill the buffer; the fifth store stalls until a pop frees a slot
    for (int i = 0; i < 4; i++) op(1, 0, 32'h10 + 4 * i, $urandom);
    set_in(1, 0, 32'h20, 32'h5555_0005);
    @(negedge clk);
    chk("t2_full_stall", {31'b0, mem_stall}, 1);
    ack_req = 1;
    @(negedge clk);
    chk("t2_ack_cycle_stall", {31'b0, mem_stall}, 1);
    @(negedge clk);
    chk("t2_accept_after_pop", {31'b0, mem_stall}, 0);
    tick();
    set_in(1, 0, 32'h24, 32'h6666_0006);
    @(negedge clk);
    chk("t2_full_again", {31'b0, mem_stall}, 1);
    auto_ack = 1;
    for (int n = 0; n < 60 && mem_stall; n++) @(negedge clk);
    chk("t2_sixth_accepted", {31'b0, mem_stall}, 0);
    tick(); idle_in();
    wait_drain(); tick(); auto_ack = 0;

    // load miss with an ack three cycles after the request rises
    set_in(0, 1, 32'h200, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall", {31'b0, mem_stall}, 1);
      if (k == 1) chk("t3_bus_req", {31'b0, bus_req}, 1);
      if (k == 3) ack_req = 1;
    end
    @(negedge clk);
    chk("t3_stall_done", {31'b0, mem_stall}, 0);
    chk("t3_rd_dm", rd_dm, 32'h1234_5678);
    tick(); idle_in();
    tick();

    // two stores to one word: load sees the younger, bus sees both in order
    op(1, 0, 32'h40, 32'h1);
    op(1, 0, 32'h40, 32'h2);
    set_in(0, 1, 32'h40, 0);
    @(negedge clk);
    chk("t4_rd_dm", rd_dm, 32'h2);
    chk("t4_stall", {31'b0, mem_stall}, 0);
    tick(); idle_in();
    auto_ack = 1; wait_drain(); tick(); auto_ack = 0;

    // load miss arriving while a write is in flight waits for it, then reads
    op(1, 0, 32'h40, 32'h7);
    tick();
    set_in(0, 1, 32'h300, 0);
    @(negedge clk);
    chk("t6_stall_wr", {31'b0, mem_stall}, 1);
    chk("t6_wr_addr", bus_addr, 32'h40);
    ack_req = 1;
    @(negedge clk);
    chk("t6_stall_wr_ack", {31'b0, mem_stall}, 1);
    @(negedge clk);
    chk("t6_stall_rd", {31'b0, mem_stall}, 1);
    chk("t6_rd_req", {30'b0, bus_req, bus_we}, 32'h2);
    chk("t6_rd_addr", bus_addr, 32'h300);
    ack_req = 1;
    @(negedge clk);
    chk("t6_stall_rd_ack", {31'b0, mem_stall}, 1);
    @(negedge clk);
    chk("t6_done", {31'b0, mem_stall}, 0);
    tick(); idle_in();
    tick();

    // asynchronous reset during a read aborts it and discards buffered stores
    op(1, 0, 32'h80, 32'h55);
    set_in(0, 1, 32'h240, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rd_busy", {31'b0, bus_req}, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_req", {31'b0, bus_req}, 0);
    chk("t5_rst_stall", {31'b0, mem_stall}, 0);
    idle_in();
    exp_wr.delete(); exp_rd.delete(); exp_ld.delete();
    ref_arch = ext_mem;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick();
    @(negedge clk);
    chk("t5_idle_req", {31'b0, bus_req}, 0);
    chk("t5_idle_stall", {31'b0, mem_stall}, 0);
    tick();
    auto_ack = 1;
    op(0, 1, 32'h80, 0);

    // random mix of stores, loads and idle cycles with random bus latency
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if (r < 4) op(1, 0, a, $urandom);
      else if (r < 8) op(0, 1, a, 0);
      else tick();
    end
    wait_drain();
    chk("end_rd_queue", exp_rd.size(), 0);
    chk("end_ld_queue", exp_ld.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
